// File: rtl/serialsubtractor_fsm.sv
// Bit-serial LSB-first subtractor: Diff = A - B - Bin over WIDTH clocks using one
// full-subtractor cell and a registered borrow, with valid/ready in and done/ack out.
module serialsubtractor_fsm #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             Clk_CI,
   input  logic             Rst_RBI,
   input  logic             Start_SI,
   output logic             Ready_SO,
   input  logic [WIDTH-1:0] A_DI,
   input  logic [WIDTH-1:0] B_DI,
   input  logic             Bin_DI,
   output logic             Done_SO,
   input  logic             Ack_SI,
   output logic [WIDTH-1:0] Diff_DO,
   output logic             Borrow_DO,
   output logic             Ovf_DO
);

   localparam int unsigned CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUSY = 2'b01,
      DONE = 2'b10
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             br_q, br_d;
   logic             sign_a_q, sign_a_d;
   logic             sign_b_q, sign_b_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             borrow_q, borrow_d;
   logic             ovf_q, ovf_d;

   logic             d_bit;
   logic             br_next;

   // Full-subtractor cell on the current operand LSBs.
   assign d_bit   = a_q[0] ^ b_q[0] ^ br_q;
   assign br_next = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      res_d    = res_q;
      cnt_d    = cnt_q;
      br_d     = br_q;
      sign_a_d = sign_a_q;
      sign_b_d = sign_b_q;
      diff_d   = diff_q;
      borrow_d = borrow_q;
      ovf_d    = ovf_q;

      case (state_q)
         IDLE: begin
            if (Start_SI) begin
               a_d      = A_DI;
               b_d      = B_DI;
               br_d     = Bin_DI;
               sign_a_d = A_DI[WIDTH-1];
               sign_b_d = B_DI[WIDTH-1];
               res_d    = '0;
               cnt_d    = '0;
               state_d  = BUSY;
            end
         end
         BUSY: begin
            a_d   = {1'b0, a_q[WIDTH-1:1]};
            b_d   = {1'b0, b_q[WIDTH-1:1]};
            res_d = {d_bit, res_q[WIDTH-1:1]};
            br_d  = br_next;
            cnt_d = cnt_q + CNT_W'(1);
            // >= rather than == so a corrupted counter still terminates.
            if (cnt_q >= LAST_BIT) begin
               state_d  = DONE;
               cnt_d    = '0;
               diff_d   = {d_bit, res_q[WIDTH-1:1]};
               borrow_d = br_next;
               ovf_d    = (sign_a_q != sign_b_q) && (d_bit != sign_a_q);
            end
         end
         DONE: begin
            if (Ack_SI) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
            br_d    = 1'b0;
         end
      endcase
   end

   always_ff @(posedge Clk_CI) begin
      if (!Rst_RBI) begin
         state_q  <= IDLE;
         a_q      <= '0;
         b_q      <= '0;
         res_q    <= '0;
         cnt_q    <= '0;
         br_q     <= 1'b0;
         sign_a_q <= 1'b0;
         sign_b_q <= 1'b0;
         diff_q   <= '0;
         borrow_q <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         res_q    <= res_d;
         cnt_q    <= cnt_d;
         br_q     <= br_d;
         sign_a_q <= sign_a_d;
         sign_b_q <= sign_b_d;
         diff_q   <= diff_d;
         borrow_q <= borrow_d;
         ovf_q    <= ovf_d;
      end
   end

   assign Ready_SO  = (state_q == IDLE);
   assign Done_SO   = (state_q == DONE);
   assign Diff_DO   = diff_q;
   assign Borrow_DO = borrow_q;
   assign Ovf_DO    = ovf_q;

endmodule

// File: tb/tb_serialsubtractor_fsm.sv
// Bench for serialsubtractor_fsm: arithmetic reference model checked every cycle,
// plus directed literal cases and a randomized back-to-back stream.
module tb_serialsubtractor_fsm;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic         bin = 1'b0;
   logic         ack = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         ready_o, done_o, borrow_o, ovf_o;
   logic [W-1:0] diff_o;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int op_num = 0;
   int prev_accept = -1;
   bit chk_en = 1'b0;

   // Model state: {ovf, borrow, diff}
   logic         m_ready, m_done;
   int           m_left;
   logic [W+1:0] m_pend, m_res;

   serialsubtractor_fsm #(.WIDTH(W)) dut (
      .Clk_CI   (clk),
      .Rst_RBI  (rst_n),
      .Start_SI (start),
      .Ready_SO (ready_o),
      .A_DI     (a),
      .B_DI     (b),
      .Bin_DI   (bin),
      .Done_SO  (done_o),
      .Ack_SI   (ack),
      .Diff_DO  (diff_o),
      .Borrow_DO(borrow_o),
      .Ovf_DO   (ovf_o)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [W+1:0] ref_sub(input logic [W-1:0] x, input logic [W-1:0] y,
                                            input logic c);
      longint u, s;
      logic [W-1:0] d;
      logic o, br;
      u  = longint'({1'b0, x}) - longint'({1'b0, y}) - longint'({1'b0, c});
      s  = longint'($signed(x)) - longint'($signed(y)) - longint'({1'b0, c});
      d  = u[W-1:0];
      br = (u < 0);
      o  = (s < -(longint'(1) << (W - 1))) || (s > (longint'(1) << (W - 1)) - 1);
      return {o, br, d};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Behavioural model: accept when idle, result appears W edges later, ack releases it.
   always @(posedge clk) begin
      if (!rst_n) begin
         m_ready <= 1'b1;
         m_done  <= 1'b0;
         m_left  <= 0;
         m_res   <= '0;
      end else if (m_ready) begin
         if (start) begin
            m_ready <= 1'b0;
            m_left  <= W;
            m_pend  <= ref_sub(a, b, bin);
         end
      end else if (m_left > 0) begin
         m_left <= m_left - 1;
         if (m_left == 1) begin
            m_done <= 1'b1;
            m_res  <= m_pend;
         end
      end else if (m_done && ack) begin
         m_done  <= 1'b0;
         m_ready <= 1'b1;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("ready", {31'b0, ready_o}, {31'b0, m_ready});
         check("done", {31'b0, done_o}, {31'b0, m_done});
         check("diff", {24'b0, diff_o}, {24'b0, m_res[W-1:0]});
         check("borrow", {31'b0, borrow_o}, {31'b0, m_res[W]});
         check("ovf", {31'b0, ovf_o}, {31'b0, m_res[W+1]});
      end
   end

   // Called at a negedge. ack_delay>0 holds ack low that many DONE cycles while pulsing start.
   task automatic run_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic obin,
                         input int ack_delay, input bit lit, input bit chk_iv,
                         input logic [W-1:0] ed, input logic eb, input logic eo);
      int n, acc, lat;
      n = 0;
      while (!ready_o && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("ready_wait", {31'b0, ready_o}, 32'd1);
      a = oa; b = ob; bin = obin; start = 1'b1; ack = (ack_delay == 0);
      @(negedge clk);
      acc = cyc;
      if (chk_iv && prev_accept >= 0) check("issue_interval", acc - prev_accept, W + 2);
      prev_accept = acc;
      n = 0;
      while (!done_o && n < 2 * W) begin
         start = 1'($urandom_range(0, 1));
         a = W'($urandom); b = W'($urandom); bin = 1'($urandom_range(0, 1));
         @(negedge clk);
         n++;
      end
      start = 1'b0;
      lat = cyc - acc;
      check("latency", lat, W);
      if (lit) begin
         check("lit_diff", {24'b0, diff_o}, {24'b0, ed});
         check("lit_borrow", {31'b0, borrow_o}, {31'b0, eb});
         check("lit_ovf", {31'b0, ovf_o}, {31'b0, eo});
      end
      $display("op %0d: A=%h B=%h Bin=%0d -> Diff=%h Borrow=%0d Ovf=%0d latency=%0d",
               op_num, oa, ob, obin, diff_o, borrow_o, ovf_o, lat);
      op_num++;
      if (ack_delay > 0) begin
         for (int i = 0; i < ack_delay; i++) begin
            start = 1'b1; a = W'($urandom); b = W'($urandom);
            @(negedge clk);
            check("held_done", {31'b0, done_o}, 32'd1);
            check("held_diff", {24'b0, diff_o}, {24'b0, ed});
            check("held_borrow", {31'b0, borrow_o}, {31'b0, eb});
         end
         ack = 1'b1;
         @(negedge clk);
         start = 1'b0;
         check("ack_ready", {31'b0, ready_o}, 32'd1);
         check("ack_done", {31'b0, done_o}, 32'd0);
         @(negedge clk);
         check("no_ack_start", {31'b0, ready_o}, 32'd1);
      end else begin
         @(negedge clk);
         check("ready_after_done", {31'b0, ready_o}, 32'd1);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk_en = 1'b1;
      check("rst_ready", {31'b0, ready_o}, 32'd1);
      check("rst_done", {31'b0, done_o}, 32'd0);
      check("rst_diff", {24'b0, diff_o}, 32'd0);
      rst_n = 1'b1;

      check("pin_model_1", {22'b0, ref_sub(8'h80, 8'h01, 1'b0)}, {22'b0, 2'b10, 8'h7F});
      check("pin_model_2", {22'b0, ref_sub(8'h7F, 8'hFF, 1'b0)}, {22'b0, 2'b11, 8'h80});
      check("pin_model_3", {22'b0, ref_sub(8'h00, 8'h00, 1'b1)}, {22'b0, 2'b01, 8'hFF});

      run_op(8'h05, 8'h03, 1'b0, 0, 1'b1, 1'b0, 8'h02, 1'b0, 1'b0);
      run_op(8'h03, 8'h05, 1'b0, 0, 1'b1, 1'b0, 8'hFE, 1'b1, 1'b0);
      run_op(8'h80, 8'h01, 1'b0, 0, 1'b1, 1'b0, 8'h7F, 1'b0, 1'b1);
      run_op(8'h7F, 8'hFF, 1'b0, 0, 1'b1, 1'b0, 8'h80, 1'b1, 1'b1);
      run_op(8'h00, 8'h00, 1'b1, 5, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0);

      // Reset mid-operation discards everything.
      a = 8'h55; b = 8'h22; bin = 1'b0; start = 1'b1; ack = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("midrst_ready", {31'b0, ready_o}, 32'd1);
      check("midrst_done", {31'b0, done_o}, 32'd0);
      check("midrst_diff", {24'b0, diff_o}, 32'd0);
      check("midrst_borrow", {31'b0, borrow_o}, 32'd0);
      check("midrst_ovf", {31'b0, ovf_o}, 32'd0);
      repeat (W + 2) @(negedge clk);
      check("midrst_no_result", {31'b0, done_o}, 32'd0);
      run_op(8'h10, 8'h01, 1'b0, 0, 1'b1, 1'b0, 8'h0F, 1'b0, 1'b0);

      prev_accept = -1;
      for (int k = 0; k < 500; k++) begin
         run_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 0, 1'b0, 1'b1,
                '0, 1'b0, 1'b0);
      end

      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
